// File: rtl/az_pkg.sv
// Shared definitions for the AZ measurement chain: combiner state encoding,
// default count width and the hi/lo phase tags also used by modulation_az.
package az_pkg;

  localparam int AZ_WIDTH = 24;

  localparam logic PHASE_HI = 1'b1;
  localparam logic PHASE_LO = 1'b0;

  typedef enum logic [1:0] {
    NEED_LO = 2'd0,
    HAVE_LO = 2'd1,
    HAVE_HI = 2'd2,
    COMPUTE = 2'd3
  } az_state_e;

endpackage

// File: rtl/az_result_holdreg.sv
// Single-entry result register with valid/ack handshake and sticky overrun.
// Load lands the next cycle; a load while full and not being acked is dropped.
module az_result_holdreg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_vld,
  input  logic [WIDTH:0]   load_value,
  input  logic [WIDTH-1:0] load_lo_mean,
  input  logic             result_ack,
  output logic             result_valid,
  output logic [WIDTH:0]   result_value,
  output logic [WIDTH-1:0] result_lo_mean,
  output logic             overrun
);

  logic             valid_q, valid_d;
  logic [WIDTH:0]   value_q, value_d;
  logic [WIDTH-1:0] lo_mean_q, lo_mean_d;
  logic             overrun_q, overrun_d;
  logic             can_load;

  // An ack in the same cycle frees the slot, so the new value may replace it.
  assign can_load = !valid_q || result_ack;

  always_comb begin
    valid_d   = valid_q;
    value_d   = value_q;
    lo_mean_d = lo_mean_q;
    overrun_d = overrun_q;
    if (clear) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else if (load_vld && can_load) begin
      valid_d   = 1'b1;
      value_d   = load_value;
      lo_mean_d = load_lo_mean;
    end else if (load_vld) begin
      overrun_d = 1'b1;
    end else if (valid_q && result_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      value_q   <= '0;
      lo_mean_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      value_q   <= value_d;
      lo_mean_q <= lo_mean_d;
      overrun_q <= overrun_d;
    end
  end

  assign result_valid   = valid_q;
  assign result_value   = value_q;
  assign result_lo_mean = lo_mean_q;
  assign overrun        = overrun_q;

endmodule

// File: rtl/az_sample_combiner.sv
// Auto-zero combiner: pairs hi counts with surrounding lo counts, result = hi - lo_mean.
// Two-lo floor averaging only when AZ_COMBINER_LO_AVG_EN is defined; otherwise the following lo is used.
module az_sample_combiner
  import az_pkg::*;
#(
  parameter int WIDTH = AZ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic             sample_is_hi,
  input  logic [WIDTH-1:0] sample_count,
  input  logic             result_ack,
  output logic             result_valid,
  output logic [WIDTH:0]   result_value,
  output logic [WIDTH-1:0] result_lo_mean,
  output logic             overrun,
  output logic             seq_err,
  output logic [1:0]       monitor
);

  az_state_e        state_q, state_d;
  logic [WIDTH-1:0] lo_prev_q, lo_prev_d;
  logic [WIDTH-1:0] hi_hold_q, hi_hold_d;
  logic             seq_err_q, seq_err_d;
  logic             res_load;
  logic [WIDTH-1:0] lo_mean;
  logic [WIDTH:0]   diff;
  logic             is_hi;

  assign is_hi = (sample_is_hi == PHASE_HI);

`ifdef AZ_COMBINER_LO_AVG_EN
  logic [WIDTH-1:0]   lo_new_q, lo_new_d;
  logic signed [WIDTH:0] lo_sum;

  // Mean of two WIDTH-bit values always fits back into WIDTH bits.
  assign lo_sum  = $signed({lo_prev_q[WIDTH-1], lo_prev_q}) + $signed({lo_new_q[WIDTH-1], lo_new_q});
  assign lo_mean = WIDTH'(lo_sum >>> 1);
`else
  // lo_prev already holds the lo that closed the pair, so it is the reference.
  assign lo_mean = lo_prev_q;
`endif

  assign diff = {hi_hold_q[WIDTH-1], hi_hold_q} - {lo_mean[WIDTH-1], lo_mean};

  always_comb begin
    state_d   = state_q;
    lo_prev_d = lo_prev_q;
    hi_hold_d = hi_hold_q;
    seq_err_d = seq_err_q;
    res_load  = 1'b0;
`ifdef AZ_COMBINER_LO_AVG_EN
    lo_new_d  = lo_new_q;
`endif
    if (clear) begin
      state_d   = NEED_LO;
      seq_err_d = 1'b0;
    end else begin
      case (state_q)
        NEED_LO: begin
          if (sample_valid) begin
            if (is_hi) begin
              seq_err_d = 1'b1;
            end else begin
              lo_prev_d = sample_count;
              state_d   = HAVE_LO;
            end
          end
        end
        HAVE_LO: begin
          if (sample_valid) begin
            if (is_hi) begin
              hi_hold_d = sample_count;
              state_d   = HAVE_HI;
            end else begin
              lo_prev_d = sample_count;
            end
          end
        end
        HAVE_HI: begin
          if (sample_valid) begin
            if (is_hi) begin
              hi_hold_d = sample_count;
              seq_err_d = 1'b1;
            end else begin
`ifdef AZ_COMBINER_LO_AVG_EN
              lo_new_d  = sample_count;
`else
              lo_prev_d = sample_count;
`endif
              state_d   = COMPUTE;
            end
          end
        end
        COMPUTE: begin
          res_load = 1'b1;
          state_d  = HAVE_LO;
`ifdef AZ_COMBINER_LO_AVG_EN
          // The closing lo becomes the leading lo of the next hi.
          lo_prev_d = lo_new_q;
`endif
          if (sample_valid) begin
            seq_err_d = 1'b1;
          end
        end
        default: state_d = NEED_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= NEED_LO;
      lo_prev_q <= '0;
      hi_hold_q <= '0;
      seq_err_q <= 1'b0;
`ifdef AZ_COMBINER_LO_AVG_EN
      lo_new_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lo_prev_q <= lo_prev_d;
      hi_hold_q <= hi_hold_d;
      seq_err_q <= seq_err_d;
`ifdef AZ_COMBINER_LO_AVG_EN
      lo_new_q  <= lo_new_d;
`endif
    end
  end

  az_result_holdreg #(
    .WIDTH(WIDTH)
  ) u_holdreg (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .load_vld      (res_load),
    .load_value    (diff),
    .load_lo_mean  (lo_mean),
    .result_ack    (result_ack),
    .result_valid  (result_valid),
    .result_value  (result_value),
    .result_lo_mean(result_lo_mean),
    .overrun       (overrun)
  );

  assign seq_err = seq_err_q;
  assign monitor = {result_valid, (state_q == COMPUTE)};

endmodule

// File: tb/tb_az_sample_combiner.sv
// Bench for az_sample_combiner; expected results are queued as stimulus is driven
// and compared when the result register presents them.
module tb_az_sample_combiner;

`ifdef AZ_COMBINER_LO_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_is_hi = 1'b0;
  logic [23:0] sample_count = '0;
  logic        result_ack = 1'b0;
  logic        result_valid;
  logic [24:0] result_value;
  logic [23:0] result_lo_mean;
  logic        overrun;
  logic        seq_err;
  logic [1:0]  monitor;

  typedef struct {
    logic [24:0] value;
    logic [23:0] mean;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  az_sample_combiner #(.WIDTH(24)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .sample_valid  (sample_valid),
    .sample_is_hi  (sample_is_hi),
    .sample_count  (sample_count),
    .result_ack    (result_ack),
    .result_valid  (result_valid),
    .result_value  (result_value),
    .result_lo_mean(result_lo_mean),
    .overrun       (overrun),
    .seq_err       (seq_err),
    .monitor       (monitor)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int value, input int mean);
    exp_t e;
    e.value = 25'(value);
    e.mean  = 24'(mean);
    sb_q.push_back(e);
  endtask

  task automatic send(input logic hi, input int cnt);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_is_hi = hi;
    sample_count = 24'(cnt);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_clears_valid: result_valid=%b required 0", tag, result_valid);
    end
  endtask

  task automatic expect_result(input string tag);
    exp_t e;
    int n = 0;
    while (result_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s result_timeout: result_valid=%b required 1", tag, result_valid);
    end else if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected_result: value=%0d, none expected", tag, $signed(result_value));
    end else begin
      e = sb_q.pop_front();
      if (result_value !== e.value) begin
        errors++;
        $display("FAIL %s value: got %0d required %0d", tag, $signed(result_value), $signed(e.value));
      end
      checks++;
      if (result_lo_mean !== e.mean) begin
        errors++;
        $display("FAIL %s lo_mean: got %0d required %0d", tag, $signed(result_lo_mean), $signed(e.mean));
      end
    end
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s no_result: result_valid rose, required 0 throughout", tag);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({result_valid, overrun, seq_err, monitor, result_value, result_lo_mean} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ovr=%b seq=%b mon=%b val=%0d mean=%0d required all 0",
               result_valid, overrun, seq_err, monitor, result_value, result_lo_mean);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    send(1'b0, 100);
    send(1'b1, 1100);
    push_exp(AVG ? 999 : 998, AVG ? 101 : 102);
    send(1'b0, 102);
    checks++;
    if (monitor !== 2'b01) begin
      errors++;
      $display("FAIL basic compute_cycle: monitor=%b required 01", monitor);
    end
    @(negedge clk);
    checks++;
    if (monitor !== 2'b10) begin
      errors++;
      $display("FAIL basic latency: monitor=%b required 10", monitor);
    end
    expect_result("basic");
    do_ack("basic");
  endtask

  task automatic test_rounding();
    do_clear();
    send(1'b0, 100);
    send(1'b1, 1000);
    push_exp(AVG ? 899 : 897, AVG ? 101 : 103);
    send(1'b0, 103);
    expect_result("round_pos");
    do_ack("round_pos");
    do_clear();
    send(1'b0, -5);
    send(1'b1, 0);
    push_exp(6, -6);
    send(1'b0, -6);
    expect_result("round_neg");
    do_ack("round_neg");
    send(1'b1, -3);
    push_exp(AVG ? 1 : -1, AVG ? -4 : -2);
    send(1'b0, -2);
    expect_result("shared_lo");
    do_ack("shared_lo");
  endtask

  task automatic test_overrun();
    do_clear();
    send(1'b0, 0);
    send(1'b1, 10);
    push_exp(10, 0);
    send(1'b0, 0);
    send(1'b1, 20);
    send(1'b0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun set: overrun=%b required 1", overrun);
    end
    expect_result("overrun_keep");
    do_ack("overrun");
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun sticky: overrun=%b required 1", overrun);
    end
    do_clear();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun clear: overrun=%b required 0", overrun);
    end
  endtask

  task automatic test_simul_ack();
    send(1'b0, 0);
    send(1'b1, 10);
    push_exp(10, 0);
    send(1'b0, 0);
    expect_result("simul_first");
    send(1'b1, 20);
    push_exp(20, 0);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_is_hi = 1'b0;
    sample_count = 24'd0;
    @(negedge clk);
    sample_valid = 1'b0;
    result_ack   = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul_ack: valid=%b overrun=%b required valid=1 overrun=0", result_valid, overrun);
    end
    expect_result("simul_ack");
    do_ack("simul_ack");
  endtask

  task automatic test_seq_err();
    do_clear();
    send(1'b1, 50);
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL seq_hi_first: seq_err=%b required 1", seq_err);
    end
    expect_idle("seq_hi_first", 3);
    send(1'b0, 0);
    send(1'b1, 5);
    send(1'b1, 7);
    push_exp(7, 0);
    send(1'b0, 0);
    expect_result("seq_hi_replace");
    do_ack("seq_hi_replace");
    do_clear();
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL seq_clear: seq_err=%b required 0", seq_err);
    end
    send(1'b1, 1);
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL clear_to_need_lo: seq_err=%b required 1", seq_err);
    end
    do_clear();
    send(1'b0, 0);
    send(1'b1, 3);
    @(negedge clk);
    clear        = 1'b1;
    sample_valid = 1'b1;
    sample_is_hi = 1'b0;
    sample_count = 24'd0;
    @(negedge clk);
    clear        = 1'b0;
    sample_valid = 1'b0;
    expect_idle("clear_priority", 3);
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority seq_err: got %b required 0", seq_err);
    end
  endtask

  task automatic test_back_to_back();
    int cnts[4] = '{1, 11, 1, 99};
    logic his[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_clear();
    push_exp(10, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_is_hi = his[i];
      sample_count = 24'(cnts[i]);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL b2b compute_ignore: seq_err=%b required 1", seq_err);
    end
    expect_result("b2b");
    do_ack("b2b");
    send(1'b1, 21);
    push_exp(20, 1);
    send(1'b0, 1);
    expect_result("b2b_after");
    do_ack("b2b_after");
  endtask

  task automatic test_async_reset();
    do_clear();
    send(1'b0, 0);
    send(1'b1, 10);
    push_exp(10, 0);
    send(1'b0, 0);
    expect_result("pre_reset");
    send(1'b1, 50);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({result_valid, overrun, seq_err, monitor, result_value, result_lo_mean} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: valid=%b ovr=%b seq=%b mon=%b val=%0d required all 0",
               result_valid, overrun, seq_err, monitor, result_value);
    end
    @(negedge clk);
    reset = 1'b1;
    send(1'b0, 4);
    expect_idle("reset_aborts_pair", 3);
    send(1'b1, 30);
    push_exp(26, 4);
    send(1'b0, 4);
    expect_result("post_reset");
    do_ack("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overrun();
    test_simul_ack();
    test_seq_err();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected results left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
